// File: rtl/mips_branch_pkg.sv
// Shared decode constants and enums for the branch resolve unit.
//   Opcode, function and REGIMM sub-op encodings for the MIPS-I jump/branch group.
//   br_fsm_t  : delay-slot tracking FSM states.
//   br_kind_t : target-source class picked by the condition decoder.
package mips_branch_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] RI_BLTZ    = 5'b00000;
  localparam logic [4:0] RI_BGEZ    = 5'b00001;
  localparam logic [4:0] RI_BLTZAL  = 5'b10000;
  localparam logic [4:0] RI_BGEZAL  = 5'b10001;

  localparam logic [4:0] LINK_RA    = 5'd31;

  typedef enum logic [1:0] {IDLE, SLOT, REDIRECT} br_fsm_t;
  typedef enum logic [1:0] {BK_NONE, BK_COND, BK_JUMP, BK_JREG} br_kind_t;
endpackage

// File: rtl/branch_cond_eval.sv
// Combinational decode of a MIPS-I jump/branch instruction.
//   Inputs : opcode/fn/rt_field/rd_field instruction fields, rs/rt operand values.
//   Outputs: is_branch_o (instruction is in the jump/branch group), taken_o (condition
//            true; jumps always), kind_o (target source), link_o (writes a link register),
//            link_reg_o (link destination).
module branch_cond_eval
  import mips_branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        opcode_i,
  input  logic [5:0]        fn_i,
  input  logic [4:0]        rt_field_i,
  input  logic [4:0]        rd_field_i,
  input  logic [DATA_W-1:0] rs_val_i,
  input  logic [DATA_W-1:0] rt_val_i,
  output logic              is_branch_o,
  output logic              taken_o,
  output br_kind_t          kind_o,
  output logic              link_o,
  output logic [4:0]        link_reg_o
);
  // Signed compares against zero reduce to sign bit and zero test.
  logic rs_neg, rs_zero, rs_eq_rt;
  assign rs_neg   = rs_val_i[DATA_W-1];
  assign rs_zero  = (rs_val_i == '0);
  assign rs_eq_rt = (rs_val_i == rt_val_i);

  always_comb begin
    is_branch_o = 1'b0;
    taken_o     = 1'b0;
    kind_o      = BK_NONE;
    link_o      = 1'b0;
    link_reg_o  = LINK_RA;
    case (opcode_i)
      OP_SPECIAL: if (fn_i == FN_JR || fn_i == FN_JALR) begin
        is_branch_o = 1'b1;
        taken_o     = 1'b1;
        kind_o      = BK_JREG;
        link_o      = (fn_i == FN_JALR);
        link_reg_o  = rd_field_i;
      end
      OP_REGIMM: case (rt_field_i)
        RI_BLTZ, RI_BGEZ, RI_BLTZAL, RI_BGEZAL: begin
          is_branch_o = 1'b1;
          kind_o      = BK_COND;
          // bit0 selects >=0 vs <0, bit4 selects the linking variants
          taken_o     = rt_field_i[0] ? !rs_neg : rs_neg;
          link_o      = rt_field_i[4];
        end
        default: ;
      endcase
      OP_J, OP_JAL: begin
        is_branch_o = 1'b1;
        taken_o     = 1'b1;
        kind_o      = BK_JUMP;
        link_o      = (opcode_i == OP_JAL);
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        is_branch_o = 1'b1;
        kind_o      = BK_COND;
        case (opcode_i)
          OP_BEQ:  taken_o = rs_eq_rt;
          OP_BNE:  taken_o = !rs_eq_rt;
          OP_BLEZ: taken_o = rs_neg || rs_zero;
          default: taken_o = !rs_neg && !rs_zero;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates jumps/branches in the EXEC state, tracks the
// architectural delay slot and raises a held PC redirect after the slot executes.
//   clk/reset          : clock, async active-high reset
//   state/stall        : core cycle state; evaluation only in EXEC_ST without stall
//   opcode..index26    : instruction fields;  rs_val/rt_val : operands;  pc : EXEC pc
//   redirect_valid/pc  : redirect request, held until a non-stalled cycle
//   in_delay_slot      : FSM is waiting for the delay-slot instruction
//   link_we/reg/val    : one-cycle link write (pc+8)
//   addr_err/nested_err: one-cycle error pulses
//   branch_cnt/taken_cnt: saturating statistics
module branch_resolve_unit
  import mips_branch_pkg::*;
#(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 32,
  parameter int                 STATE_W = 4,
  parameter logic [STATE_W-1:0] EXEC_ST = STATE_W'(2),
  parameter int                 CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  input  logic               stall,
  input  logic [5:0]         opcode,
  input  logic [5:0]         fn,
  input  logic [4:0]         rt_field,
  input  logic [4:0]         rd_field,
  input  logic [15:0]        imm16,
  input  logic [25:0]        index26,
  input  logic [DATA_W-1:0]  rs_val,
  input  logic [DATA_W-1:0]  rt_val,
  input  logic [ADDR_W-1:0]  pc,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_pc,
  output logic               in_delay_slot,
  output logic               link_we,
  output logic [4:0]         link_reg,
  output logic [DATA_W-1:0]  link_val,
  output logic               addr_err,
  output logic               nested_err,
  output logic [CNT_W-1:0]   branch_cnt,
  output logic [CNT_W-1:0]   taken_cnt
);
  logic     is_branch, cond_taken, link;
  logic [4:0] lreg;
  br_kind_t kind;

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .opcode_i   (opcode),
    .fn_i       (fn),
    .rt_field_i (rt_field),
    .rd_field_i (rd_field),
    .rs_val_i   (rs_val),
    .rt_val_i   (rt_val),
    .is_branch_o(is_branch),
    .taken_o    (cond_taken),
    .kind_o     (kind),
    .link_o     (link),
    .link_reg_o (lreg)
  );

  logic evaluate;
  assign evaluate = (state == EXEC_ST) && !stall;

  // Target arithmetic, all modulo 2^ADDR_W.
  logic [ADDR_W-1:0] pc_plus4, pc_plus8, imm_off, br_target, j_target, target;
  assign pc_plus4  = pc + ADDR_W'(4);
  assign pc_plus8  = pc + ADDR_W'(8);
  assign imm_off   = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
  assign br_target = pc_plus4 + imm_off;
  // Keep the region bits above 28 from pc+4; mask form also covers ADDR_W == 28.
  assign j_target  = (pc_plus4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({index26, 2'b00});

  always_comb begin
    case (kind)
      BK_JUMP: target = j_target;
      BK_JREG: target = rs_val[ADDR_W-1:0];
      default: target = br_target;
    endcase
  end

  logic misaligned, take;
  assign misaligned = (kind == BK_JREG) && (target[1:0] != 2'b00);
  assign take       = is_branch && cond_taken && !misaligned;

  br_fsm_t           fsm_q;
  logic              redirect_valid_q, link_we_q, addr_err_q, nested_err_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic [4:0]        link_reg_q;
  logic [DATA_W-1:0] link_val_q;
  logic [CNT_W-1:0]  branch_cnt_q, taken_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q            <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      link_we_q        <= 1'b0;
      link_reg_q       <= '0;
      link_val_q       <= '0;
      addr_err_q       <= 1'b0;
      nested_err_q     <= 1'b0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else begin
      link_we_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      nested_err_q <= 1'b0;
      case (fsm_q)
        IDLE: if (evaluate && is_branch) begin
          if (~&branch_cnt_q) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
          addr_err_q <= misaligned;
          // Link is written whether or not the branch is taken.
          if (link) begin
            link_we_q  <= 1'b1;
            link_reg_q <= lreg;
            link_val_q <= DATA_W'(pc_plus8);
          end
          if (take) begin
            fsm_q         <= SLOT;
            redirect_pc_q <= target;
            if (~&taken_cnt_q) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
          end
        end
        // Delay-slot instruction executes here; a branch in it is flagged and dropped.
        SLOT: if (evaluate) begin
          nested_err_q     <= is_branch;
          fsm_q            <= REDIRECT;
          redirect_valid_q <= 1'b1;
        end
        REDIRECT: if (!stall) begin
          fsm_q            <= IDLE;
          redirect_valid_q <= 1'b0;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign in_delay_slot  = (fsm_q == SLOT);
  assign link_we        = link_we_q;
  assign link_reg       = link_reg_q;
  assign link_val       = link_val_q;
  assign addr_err       = addr_err_q;
  assign nested_err     = nested_err_q;
  assign branch_cnt     = branch_cnt_q;
  assign taken_cnt      = taken_cnt_q;
endmodule
